// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Round-robin arbiter and sequencer that shares one memory port between two
// requesters (typically instruction fetch and load/store). A granted request
// is captured into local registers, issued on the memory side until it is
// acknowledged or times out, then reported back with a one-cycle done pulse.
module mem_port_arbiter #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_0,
  input  logic              i_req_1,
  input  logic              i_we_0,
  input  logic              i_we_1,
  input  logic [ADDR_W-1:0] i_addr_0,
  input  logic [ADDR_W-1:0] i_addr_1,
  input  logic [DATA_W-1:0] i_wdata_0,
  input  logic [DATA_W-1:0] i_wdata_1,
  output logic              o_done_0,
  output logic              o_done_1,
  output logic              o_err,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_sel,
  output logic              o_busy,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Counter only has to reach TIMEOUT-1, so clog2(TIMEOUT) bits suffice.
  localparam int              CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Round-robin pick: on a tie the requester that was not granted last wins.
  function automatic logic pick_grant(input logic req_a, input logic req_b,
                                      input logic last_grant);
    logic g;
    if (req_a && req_b) begin
      g = ~last_grant;
    end else if (req_b) begin
      g = 1'b1;
    end else begin
      g = 1'b0;
    end
    return g;
  endfunction

  // Registered state
  logic [1:0]        state_r;
  logic              ptr_r;
  logic              sel_r;
  logic              we_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] rdata_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              err_r;
  logic              done_0_r;
  logic              done_1_r;
  logic              mem_req_r;
  logic              busy_r;

  // Next-state values
  logic [1:0]        state_s;
  logic              ptr_s;
  logic              sel_s;
  logic              we_s;
  logic [ADDR_W-1:0] addr_s;
  logic [DATA_W-1:0] wdata_s;
  logic [DATA_W-1:0] rdata_s;
  logic [CNT_W-1:0]  cnt_s;
  logic              err_s;
  logic              done_0_s;
  logic              done_1_s;
  logic              mem_req_s;
  logic              grant_s;

  // Grant candidate from the live request lines (only consumed in IDLE).
  always_comb begin
    grant_s = pick_grant(i_req_0, i_req_1, ptr_r);
  end

  // Sequencer: computes the next value of every register from the current state.
  always_comb begin
    state_s   = state_r;
    ptr_s     = ptr_r;
    sel_s     = sel_r;
    we_s      = we_r;
    addr_s    = addr_r;
    wdata_s   = wdata_r;
    rdata_s   = rdata_r;
    cnt_s     = cnt_r;
    err_s     = 1'b0;
    done_0_s  = 1'b0;
    done_1_s  = 1'b0;
    mem_req_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_req_0 || i_req_1) begin
          // Capture the granted request; inputs are not looked at again
          // until the transaction has been reported.
          sel_s     = grant_s;
          ptr_s     = grant_s;
          we_s      = grant_s ? i_we_1    : i_we_0;
          addr_s    = grant_s ? i_addr_1  : i_addr_0;
          wdata_s   = grant_s ? i_wdata_1 : i_wdata_0;
          cnt_s     = {CNT_W{1'b0}};
          mem_req_s = 1'b1;
          state_s   = ST_ISSUE;
        end else begin
          // o_sel keeps its last value so the shared muxes do not glitch.
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (i_mem_ack) begin
          // Ack takes priority over a timeout reached in the same cycle.
          rdata_s  = we_r ? {DATA_W{1'b0}} : i_mem_rdata;
          done_0_s = ~sel_r;
          done_1_s = sel_r;
          state_s  = ST_DONE;
        end else if (cnt_r == CNT_LAST) begin
          rdata_s  = {DATA_W{1'b0}};
          err_s    = 1'b1;
          done_0_s = ~sel_r;
          done_1_s = sel_r;
          state_s  = ST_DONE;
        end else begin
          cnt_s     = cnt_r + CNT_ONE;
          mem_req_s = 1'b1;
          state_s   = ST_ISSUE;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset leaves every output low and the
  // pointer at 1 so requester 0 wins the first tie.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r   <= ST_IDLE;
      ptr_r     <= 1'b1;
      sel_r     <= 1'b0;
      we_r      <= 1'b0;
      addr_r    <= {ADDR_W{1'b0}};
      wdata_r   <= {DATA_W{1'b0}};
      rdata_r   <= {DATA_W{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      err_r     <= 1'b0;
      done_0_r  <= 1'b0;
      done_1_r  <= 1'b0;
      mem_req_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      ptr_r     <= ptr_s;
      sel_r     <= sel_s;
      we_r      <= we_s;
      addr_r    <= addr_s;
      wdata_r   <= wdata_s;
      rdata_r   <= rdata_s;
      cnt_r     <= cnt_s;
      err_r     <= err_s;
      done_0_r  <= done_0_s;
      done_1_r  <= done_1_s;
      mem_req_r <= mem_req_s;
      busy_r    <= (state_s != ST_IDLE);
    end
  end

  assign o_done_0    = done_0_r;
  assign o_done_1    = done_1_r;
  assign o_err       = err_r;
  assign o_rdata     = rdata_r;
  assign o_sel       = sel_r;
  assign o_busy      = busy_r;
  assign o_mem_req   = mem_req_r;
  assign o_mem_we    = we_r;
  assign o_mem_addr  = addr_r;
  assign o_mem_wdata = wdata_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed transactions, a scoreboard of expected
// done reports checked by a monitor, and a memory responder that checks the
// issued address/data and acknowledges after a programmable delay.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req_0, req_1, we_0, we_1;
  logic [31:0] addr_0, addr_1, wdata_0, wdata_1;
  logic        done_0, done_1, err, sel, busy;
  logic [31:0] rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  mem_port_arbiter #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_0(req_0), .i_req_1(req_1), .i_we_0(we_0), .i_we_1(we_1),
    .i_addr_0(addr_0), .i_addr_1(addr_1),
    .i_wdata_0(wdata_0), .i_wdata_1(wdata_1),
    .o_done_0(done_0), .o_done_1(done_1), .o_err(err), .o_rdata(rdata),
    .o_sel(sel), .o_busy(busy),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { logic port; logic err; logic [31:0] rdata; } exp_t;
  typedef struct packed { logic we; logic [31:0] addr; logic [31:0] wdata; } mexp_t;
  exp_t  exp_q[$];
  mexp_t mexp_q[$];

  int n_cmp  = 0;
  int n_fail = 0;

  // memory responder controls (written only by the stimulus process)
  logic        ack_en    = 1'b1;
  int          ack_delay = 0;
  logic [31:0] rdata_val = 32'h0;
  logic        idle_ack  = 1'b0;
  int          req_len_last;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory responder: checks the issued fields on the first request cycle and
  // acks after ack_delay further cycles; can also ack spuriously while idle.
  int  resp_cyc;
  always @(negedge clk) begin
    if (!rst_n) begin
      resp_cyc  = 0;
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
    end else if (mem_req) begin
      if (resp_cyc == 0) begin
        if (mexp_q.size() == 0) begin
          check("unexpected_issue", 64'(mexp_q.size()), 64'd1);
        end else begin
          mexp_t m;
          m = mexp_q.pop_front();
          check("mem_we",    64'(mem_we),    64'(m.we));
          check("mem_addr",  64'(mem_addr),  64'(m.addr));
          check("mem_wdata", 64'(mem_wdata), 64'(m.wdata));
          check("busy_issue", 64'(busy), 64'd1);
        end
      end
      if (ack_en && resp_cyc == ack_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = rdata_val;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
      end
      resp_cyc++;
    end else begin
      if (resp_cyc != 0) req_len_last = resp_cyc;
      resp_cyc  = 0;
      mem_ack   = idle_ack;
      mem_rdata = idle_ack ? 32'hBAD0_BAD0 : 32'h0;
    end
  end

  // Monitor: every done pulse is matched against the next scoreboard entry.
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (done_0 || done_1) begin
        if (prev_done) check("done_width", 64'd2, 64'd1);
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'(exp_q.size()), 64'd1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("done_port",  64'({done_1, done_0}), e.port ? 64'd2 : 64'd1);
          check("done_sel",   64'(sel),   64'(e.port));
          check("done_err",   64'(err),   64'(e.err));
          check("done_rdata", 64'(rdata), 64'(e.rdata));
          check("done_memreq", 64'(mem_req), 64'd0);
        end
      end else if (err) begin
        check("err_without_done", 64'(err), 64'd0);
      end
      prev_done = done_0 || done_1;
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(done_0 || done_1) && cyc < 200);
    if (!(done_0 || done_1)) check("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic push(input logic port, input logic e_err, input logic [31:0] e_rd,
                      input logic m_we, input logic [31:0] m_addr, input logic [31:0] m_wd);
    exp_q.push_back('{port: port, err: e_err, rdata: e_rd});
    mexp_q.push_back('{we: m_we, addr: m_addr, wdata: m_wd});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    // T1: reset with both requests high
    rst_n = 1'b0;
    req_0 = 1'b1; we_0 = 1'b0; addr_0 = 32'h0000_0004; wdata_0 = 32'h0;
    req_1 = 1'b1; we_1 = 1'b0; addr_1 = 32'h0000_0008; wdata_1 = 32'h0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", 64'({done_0, done_1, err, sel, busy, mem_req, mem_we}), 64'd0);
    check("reset_data", 64'({rdata, mem_addr}), 64'd0);
    check("reset_wdata", 64'(mem_wdata), 64'd0);
    rdata_val = 32'h1111_2222; ack_delay = 1;
    push(1'b0, 1'b0, 32'h1111_2222, 1'b0, 32'h0000_0004, 32'h0);
    push(1'b1, 1'b0, 32'h1111_2222, 1'b0, 32'h0000_0008, 32'h0);
    rst_n = 1'b1;
    wait_done(c); req_0 = 1'b0;
    wait_done(c); req_1 = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_sel_hold", 64'(sel), 64'd1);
    check("idle_busy", 64'(busy), 64'd0);

    // T2: single read from requester 1, ack after 2 cycles
    rdata_val = 32'hDEAD_BEEF; ack_delay = 2;
    addr_1 = 32'h0000_0010; wdata_1 = 32'h0000_0077;
    push(1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'h0000_0010, 32'h0000_0077);
    req_1 = 1'b1;
    wait_done(c); req_1 = 1'b0;
    @(negedge clk);

    // T3: both requesting continuously, 4 transactions alternate 0,1,0,1
    rdata_val = 32'hCAFE_0001; ack_delay = 0;
    addr_0 = 32'h0000_0100; we_0 = 1'b0; wdata_0 = 32'h0000_000A;
    addr_1 = 32'h0000_0104; we_1 = 1'b1; wdata_1 = 32'h55AA_55AA;
    for (int i = 0; i < 2; i++) begin
      push(1'b0, 1'b0, 32'hCAFE_0001, 1'b0, 32'h0000_0100, 32'h0000_000A);
      push(1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0104, 32'h55AA_55AA);
    end
    req_0 = 1'b1; req_1 = 1'b1;
    for (int i = 0; i < 4; i++) wait_done(c);
    req_0 = 1'b0; req_1 = 1'b0; we_1 = 1'b0;
    @(negedge clk);

    // T4: write from requester 0, ack in first ISSUE cycle
    rdata_val = 32'hFFFF_FFFF; ack_delay = 0;
    we_0 = 1'b1; addr_0 = 32'h0000_0020; wdata_0 = 32'h1234_5678;
    push(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0020, 32'h1234_5678);
    req_0 = 1'b1;
    wait_done(c); req_0 = 1'b0; we_0 = 1'b0;
    check("t4_latency", 64'(c), 64'd2);
    @(negedge clk);

    // T5: no ack -> timeout after 16 request cycles
    ack_en = 1'b0; rdata_val = 32'h7777_7777;
    addr_1 = 32'h0000_0030; wdata_1 = 32'h0;
    push(1'b1, 1'b1, 32'h0, 1'b0, 32'h0000_0030, 32'h0);
    req_1 = 1'b1;
    wait_done(c); req_1 = 1'b0;
    @(negedge clk);
    check("t5_req_len", 64'(req_len_last), 64'd16);

    // T5b: ack on the last allowed cycle wins over the timeout
    ack_en = 1'b1; ack_delay = 15; rdata_val = 32'h0BAD_F00D;
    push(1'b1, 1'b0, 32'h0BAD_F00D, 1'b0, 32'h0000_0030, 32'h0);
    req_1 = 1'b1;
    wait_done(c); req_1 = 1'b0;
    @(negedge clk);
    check("t5b_req_len", 64'(req_len_last), 64'd16);

    // T6: reset during ISSUE, then the pending requester is re-served
    ack_en = 1'b0;
    we_0 = 1'b0; addr_0 = 32'h0000_0040; wdata_0 = 32'h0;
    mexp_q.push_back('{we: 1'b0, addr: 32'h0000_0040, wdata: 32'h0});
    req_0 = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_req_before_rst", 64'(mem_req), 64'd1);
    rst_n = 1'b0;
    #1;
    check("t6_async_req", 64'(mem_req), 64'd0);
    check("t6_async_busy", 64'(busy), 64'd0);
    repeat (2) @(negedge clk);
    ack_en = 1'b1; ack_delay = 1; rdata_val = 32'h6666_0040;
    push(1'b0, 1'b0, 32'h6666_0040, 1'b0, 32'h0000_0040, 32'h0);
    rst_n = 1'b1;
    wait_done(c); req_0 = 1'b0;
    check("t6_latency", 64'(c), 64'd3);
    @(negedge clk);

    // Ack while idle must be ignored
    idle_ack = 1'b1;
    repeat (3) @(negedge clk);
    idle_ack = 1'b0;
    @(negedge clk);
    check("idle_ack_busy", 64'(busy), 64'd0);
    check("idle_ack_rdata", 64'(rdata), 64'h6666_0040);
    check("idle_ack_req", 64'(mem_req), 64'd0);

    repeat (3) @(negedge clk);
    check("exp_q_drained",  64'(exp_q.size()),  64'd0);
    check("mexp_q_drained", 64'(mexp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
